conv_sequencer: RTL

Control sequencer for the 128-sample by 32-tap parallel convolution datapath: x sample buffer, f tap buffer, 32-lane multiply/adder tree and output register. It accepts one frame of N x samples and M f taps over independent valid/ready streams, then steps the window start address from 0 to N-M. It issues one buffer read and one accumulator load per window and presents each of the N-M+1 results on a valid/ready output with full backpressure. The datapath itself contains no control state; all write enables, addresses and accumulator strobes come from this block.

---
 rtl/conv_pkg.sv | 12 +
 rtl/load_counter.sv | 34 +++
 rtl/conv_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared sizes, state encoding and result type for the convolution sequencer
package conv_pkg;
  localparam int N     = 128;
  localparam int M     = 32;
  localparam int LOGN  = 7;
  localparam int LOGM  = 5;
  localparam int NUM_Y = N - M + 1;

  typedef enum logic [2:0] {LOAD, ISSUE, CAPT, PIPE, VALID} seq_state_t;

  typedef logic signed [20:0] conv_result_t;
endpackage

// File: rtl/load_counter.sv
// rtl/load_counter.sv - per-stream fill counter: ready, write strobe and write address
module load_counter #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          full_next
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  // One bit wider than the address so the count can hold DEPTH itself.
  logic [AW:0] cnt;

  assign s_ready   = enable && !reset && (cnt < FULL);
  assign wr_en     = s_valid && s_ready;
  assign wr_addr   = cnt[AW-1:0];
  assign full_next = (cnt == FULL) || (wr_en && (cnt == LAST));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (wr_en) begin
      cnt <= cnt + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - frame load, window stepping and result handshake for the convolution datapath
// Option CONV_SEQ_PIPE_EN inserts a PIPE state after CAPT for a registered adder tree.
module conv_sequencer
  import conv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid_x,
  output logic            s_ready_x,
  input  logic            s_valid_f,
  output logic            s_ready_f,
  output logic            x_wr_en,
  output logic [LOGN-1:0] x_wr_addr,
  output logic            f_wr_en,
  output logic [LOGM-1:0] f_wr_addr,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_x,
  output logic            acc_clr,
  output logic            acc_ld,
  output logic            m_valid_y,
  input  logic            m_ready_y,
  output logic [LOGN-1:0] y_idx,
  output logic            frame_done,
  output logic            busy
);
  localparam logic [LOGN-1:0] LAST_WIN = LOGN'(NUM_Y - 1);

  seq_state_t      state, state_n;
  logic [LOGN-1:0] win;
  logic            in_load, x_full_next, f_full_next, load_done;
  logic            y_accept, last_accept, frame_done_q;

  assign in_load     = (state == LOAD);
  assign y_accept    = (state == VALID) && m_ready_y && !reset;
  assign last_accept = y_accept && (win == LAST_WIN);
  // Leave LOAD in the same cycle as the handshake that completes both buffers.
  assign load_done   = in_load && x_full_next && f_full_next && !reset;

  load_counter #(.DEPTH(N), .AW(LOGN)) u_x_cnt (
    .clk       (clk),
    .reset     (reset),
    .enable    (in_load),
    .clear     (last_accept),
    .s_valid   (s_valid_x),
    .s_ready   (s_ready_x),
    .wr_en     (x_wr_en),
    .wr_addr   (x_wr_addr),
    .full_next (x_full_next)
  );

  load_counter #(.DEPTH(M), .AW(LOGM)) u_f_cnt (
    .clk       (clk),
    .reset     (reset),
    .enable    (in_load),
    .clear     (last_accept),
    .s_valid   (s_valid_f),
    .s_ready   (s_ready_f),
    .wr_en     (f_wr_en),
    .wr_addr   (f_wr_addr),
    .full_next (f_full_next)
  );

  always_comb begin
    state_n   = state;
    rd_en     = 1'b0;
    acc_ld    = 1'b0;
    m_valid_y = 1'b0;
    case (state)
      LOAD:  if (load_done) state_n = ISSUE;
      ISSUE: begin
        rd_en   = 1'b1;
        state_n = CAPT;
      end
      CAPT: begin
        acc_ld = 1'b1;
`ifdef CONV_SEQ_PIPE_EN
        state_n = PIPE;
`else
        state_n = VALID;
`endif
      end
`ifdef CONV_SEQ_PIPE_EN
      PIPE:  state_n = VALID;
`endif
      VALID: begin
        m_valid_y = 1'b1;
        if (m_ready_y) state_n = (win == LAST_WIN) ? LOAD : ISSUE;
      end
      default: state_n = LOAD;
    endcase
    // Reset is synchronous, so the old state is still registered; mask its strobes.
    if (reset) begin
      rd_en     = 1'b0;
      acc_ld    = 1'b0;
      m_valid_y = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOAD;
      win          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      frame_done_q <= last_accept;
      if (y_accept) win <= (win == LAST_WIN) ? '0 : win + LOGN'(1);
    end
  end

  assign rd_addr_x  = win;
  assign y_idx      = win;
  assign acc_clr    = reset || load_done;
  assign frame_done = frame_done_q;
  assign busy       = !reset && !in_load;
endmodule
